// File: rtl/fft_stage_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT. It walks every stage,
// issues one butterfly per accepted handshake and drains write-backs between stages.
module fft_stage_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int TW_WIDTH   = 11
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_DATA_LOADED,
  input  logic [ADDR_WIDTH-1:0] i_SAMPLES_NUMBER,
  input  logic                  i_BFLY_READY,
  input  logic                  i_WB_VALID,
  output logic                  o_BFLY_VALID,
  output logic [ADDR_WIDTH-1:0] o_ADDR_A,
  output logic [ADDR_WIDTH-1:0] o_ADDR_B,
  output logic [TW_WIDTH-1:0]   o_TWIDDLE_IDX,
  output logic [3:0]            o_STAGE,
  output logic                  o_BUSY,
  output logic                  o_CALC_END,
  output logic                  o_ERR
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] n_lat, k, k_nxt, last_k, outstanding, out_nxt;
  logic [3:0]            stage, stage_nxt, log2n, chk_log2;
  logic                  legal, xfer;

  // Upper leg: insert a zero at bit 'st' of k, i.e. group base plus offset j.
  function automatic logic [ADDR_WIDTH-1:0] addr_a_f(input logic [ADDR_WIDTH-1:0] kk,
                                                     input logic [3:0] st);
    logic [ADDR_WIDTH-1:0] msk;
    msk = (ADDR_WIDTH'(1) << st) - ADDR_WIDTH'(1);
    return ((kk >> st) << (st + 4'd1)) | (kk & msk);
  endfunction

  function automatic logic [TW_WIDTH-1:0] tw_f(input logic [ADDR_WIDTH-1:0] kk,
                                               input logic [3:0] st, input logic [3:0] lg);
    logic [ADDR_WIDTH-1:0] msk;
    msk = (ADDR_WIDTH'(1) << st) - ADDR_WIDTH'(1);
    return TW_WIDTH'((kk & msk) << (lg - 4'd1 - st));
  endfunction

  always_comb begin
    chk_log2 = '0;
    for (int i = 0; i < ADDR_WIDTH; i++)
      if (n_lat[i]) chk_log2 = 4'(i);
  end

  assign legal     = (n_lat >= ADDR_WIDTH'(4)) && ((n_lat & (n_lat - ADDR_WIDTH'(1))) == '0);
  assign last_k    = (n_lat >> 1) - ADDR_WIDTH'(1);
  assign k_nxt     = k + ADDR_WIDTH'(1);
  assign stage_nxt = stage + 4'd1;
  assign xfer      = (state == S_ISSUE) && o_BFLY_VALID && i_BFLY_READY;
  assign o_STAGE   = stage;

  // Issue and retire in the same cycle cancel; a retire with nothing in flight is dropped.
  always_comb begin
    out_nxt = outstanding;
    if (xfer && !i_WB_VALID)
      out_nxt = outstanding + ADDR_WIDTH'(1);
    else if (!xfer && i_WB_VALID && (outstanding != '0))
      out_nxt = outstanding - ADDR_WIDTH'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      n_lat         <= '0;
      log2n         <= '0;
      k             <= '0;
      stage         <= '0;
      outstanding   <= '0;
      o_BFLY_VALID  <= 1'b0;
      o_ADDR_A      <= '0;
      o_ADDR_B      <= '0;
      o_TWIDDLE_IDX <= '0;
      o_BUSY        <= 1'b0;
      o_CALC_END    <= 1'b0;
      o_ERR         <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_DATA_LOADED) begin
            n_lat      <= i_SAMPLES_NUMBER;
            o_ERR      <= 1'b0;
            o_CALC_END <= 1'b0;
            o_BUSY     <= 1'b1;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!legal) begin
            o_ERR  <= 1'b1;
            o_BUSY <= 1'b0;
            state  <= S_ERR;
          end else begin
            log2n         <= chk_log2;
            stage         <= '0;
            k             <= '0;
            o_BFLY_VALID  <= 1'b1;
            o_ADDR_A      <= '0;
            o_ADDR_B      <= ADDR_WIDTH'(1);
            o_TWIDDLE_IDX <= '0;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (xfer) begin
            if (k == last_k) begin
              o_BFLY_VALID <= 1'b0;
              state        <= S_DRAIN;
            end else begin
              k             <= k_nxt;
              o_ADDR_A      <= addr_a_f(k_nxt, stage);
              o_ADDR_B      <= addr_a_f(k_nxt, stage) + (ADDR_WIDTH'(1) << stage);
              o_TWIDDLE_IDX <= tw_f(k_nxt, stage, log2n);
            end
          end
        end
        S_DRAIN: begin
          // Look at the post-update count so the stage advances right after the last retire.
          if (out_nxt == '0) begin
            if (stage == log2n - 4'd1) begin
              o_BUSY     <= 1'b0;
              o_CALC_END <= 1'b1;
              state      <= S_DONE;
            end else begin
              stage         <= stage_nxt;
              k             <= '0;
              o_BFLY_VALID  <= 1'b1;
              o_ADDR_A      <= '0;
              o_ADDR_B      <= ADDR_WIDTH'(1) << stage_nxt;
              o_TWIDDLE_IDX <= '0;
              state         <= S_ISSUE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: a group/offset FFT model fills the expected
// queue, a negedge monitor pops it on every handshake and checks drain/hold timing.
module tb_fft_stage_sequencer;
  localparam int AW = 12;
  localparam int TW = 11;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_DATA_LOADED = 1'b0;
  logic [AW-1:0] i_SAMPLES_NUMBER = '0;
  logic          i_BFLY_READY = 1'b0;
  logic          i_WB_VALID = 1'b0;
  logic          o_BFLY_VALID;
  logic [AW-1:0] o_ADDR_A, o_ADDR_B;
  logic [TW-1:0] o_TWIDDLE_IDX;
  logic [3:0]    o_STAGE;
  logic          o_BUSY, o_CALC_END, o_ERR;

  fft_stage_sequencer #(.ADDR_WIDTH(AW), .TW_WIDTH(TW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_DATA_LOADED(i_DATA_LOADED),
    .i_SAMPLES_NUMBER(i_SAMPLES_NUMBER), .i_BFLY_READY(i_BFLY_READY),
    .i_WB_VALID(i_WB_VALID), .o_BFLY_VALID(o_BFLY_VALID), .o_ADDR_A(o_ADDR_A),
    .o_ADDR_B(o_ADDR_B), .o_TWIDDLE_IDX(o_TWIDDLE_IDX), .o_STAGE(o_STAGE),
    .o_BUSY(o_BUSY), .o_CALC_END(o_CALC_END), .o_ERR(o_ERR)
  );

  initial forever #5 i_clk = ~i_clk;

  typedef struct { int a; int b; int tw; int st; } bfly_t;
  bfly_t expq[$];
  int    wbq[$];
  int    checks = 0, failures = 0;
  int    cyc = 0, last_wb_cyc = -100, xfer_cnt = 0, last_stage = -1;
  int    wb_lat = 3, rdy_mode = 0, stall_at = 0, stall_left = 0;
  logic  stray_wb = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: for each stage, walk groups of 2*half and offsets j within a group.
  task automatic push_frame(input int n);
    int lg, half;
    bfly_t e;
    lg = 0;
    while ((1 << lg) < n) lg++;
    for (int s = 0; s < lg; s++) begin
      half = 1 << s;
      for (int g = 0; g < n; g += 2 * half)
        for (int j = 0; j < half; j++) begin
          e.a = g + j; e.b = g + j + half; e.tw = j * (n / (2 * half)); e.st = s;
          expq.push_back(e);
        end
    end
  endtask

  // Input driver: write-backs a fixed latency after each handshake, READY policy.
  initial begin
    logic wb;
    forever begin
      @(posedge i_clk);
      cyc++;
      #2;
      wb = stray_wb;
      if (wbq.size() > 0 && wbq[0] == cyc) begin
        void'(wbq.pop_front());
        wb = 1'b1;
        last_wb_cyc = cyc;
      end
      i_WB_VALID = wb;
      if (stall_left > 0 && xfer_cnt == stall_at) begin
        i_BFLY_READY = 1'b0;
        stall_left--;
      end else if (rdy_mode == 1) i_BFLY_READY = ($urandom_range(0, 3) != 0);
      else i_BFLY_READY = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each accepted bundle.
  initial begin
    logic          prev_stall, prev_valid;
    logic [AW-1:0] pa, pb;
    logic [TW-1:0] ptw;
    bfly_t         e;
    prev_stall = 1'b0; prev_valid = 1'b0; pa = '0; pb = '0; ptw = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) prev_stall = 1'b0;
      else begin
        if (prev_stall)
          chk("hold_bundle", {o_BFLY_VALID, o_ADDR_A, o_ADDR_B, o_TWIDDLE_IDX}, {1'b1, pa, pb, ptw});
        if (o_BFLY_VALID && !prev_valid && expq.size() > 0 && expq[0].st != 0) begin
          chk("stage_gap_after_last_wb", cyc - last_wb_cyc, 1);
          chk("wb_pending_at_stage_start", wbq.size(), 0);
        end
        if (o_BFLY_VALID && i_BFLY_READY) begin
          if (expq.size() == 0) begin
            checks++; failures++;
            $display("FAIL spurious_xfer: got A=%0d B=%0d expected no transfer", o_ADDR_A, o_ADDR_B);
          end else begin
            e = expq.pop_front();
            chk("addr_a", o_ADDR_A, e.a);
            chk("addr_b", o_ADDR_B, e.b);
            chk("twiddle", o_TWIDDLE_IDX, e.tw);
            chk("stage", o_STAGE, e.st);
            last_stage = e.st;
          end
          xfer_cnt++;
          wbq.push_back(cyc + wb_lat);
        end else if (o_BFLY_VALID && expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_valid: got valid=1 expected 0");
        end
        prev_stall = o_BFLY_VALID && !i_BFLY_READY;
        pa = o_ADDR_A; pb = o_ADDR_B; ptw = o_TWIDDLE_IDX;
      end
      prev_valid = o_BFLY_VALID;
    end
  end

  task automatic start_frame(input int n, input bit legal, input bit exp_done);
    if (legal) push_frame(n);
    xfer_cnt = 0;
    @(posedge i_clk); #2;
    i_SAMPLES_NUMBER = n[AW-1:0];
    i_DATA_LOADED = 1'b1;
    @(negedge i_clk);
    if (exp_done) chk("calc_end_before_restart", o_CALC_END, 1);
    @(posedge i_clk); #2;
    i_DATA_LOADED = 1'b0;
    @(negedge i_clk);
    chk("check_busy", o_BUSY, 1);
    chk("check_calc_end_low", o_CALC_END, 0);
    chk("check_err_clear", o_ERR, 0);
    chk("check_no_valid", o_BFLY_VALID, 0);
    @(negedge i_clk);
    if (legal) chk("first_valid_latency", o_BFLY_VALID, 1);
    else begin
      chk("err_set", o_ERR, 1);
      chk("err_no_valid", o_BFLY_VALID, 0);
      chk("err_busy", o_BUSY, 0);
      chk("err_calc_end", o_CALC_END, 0);
    end
  endtask

  task automatic finish_frame(input int exp_x);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 40000 && !seen; t++) begin
      @(negedge i_clk);
      seen = o_CALC_END;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL calc_end_timeout: got calc_end=0 expected 1 (xfers=%0d)", xfer_cnt);
      expq.delete();
    end else begin
      chk("calc_end_latency", cyc - last_wb_cyc, 1);
      chk("xfer_count", xfer_cnt, exp_x);
      chk("scoreboard_empty", expq.size(), 0);
      chk("done_busy", o_BUSY, 0);
      chk("done_err", o_ERR, 0);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {o_BFLY_VALID, o_ADDR_A, o_ADDR_B, o_TWIDDLE_IDX, o_STAGE, o_BUSY, o_CALC_END, o_ERR}, 0);
  endtask

  initial begin
    int ilg[3];
    int n, lg;
    bit ok;
    ilg[0] = 12; ilg[1] = 2; ilg[2] = 4096;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk_all_zero("reset_outputs");
    @(posedge i_clk); #2;
    i_rst = 1'b0;

    // N=8, READY=1, write-back 3 cycles after issue
    wb_lat = 3; rdy_mode = 0;
    start_frame(8, 1, 0);
    finish_frame(12);

    // Backpressure mid-stage, N=4, restarted from DONE
    stall_at = 1; stall_left = 5;
    start_frame(4, 1, 1);
    finish_frame(4);
    chk("stall_applied", stall_left, 0);

    // Illegal sizes, then a legal start clears the error
    for (int i = 0; i < 3; i++) begin
      start_frame(ilg[i], 0, i == 0);
      repeat (4) begin
        @(negedge i_clk);
        chk("err_stays_idle", {o_BFLY_VALID, o_ERR}, 2'b01);
      end
    end
    wb_lat = $urandom_range(1, 6); rdy_mode = 1;
    start_frame(16, 1, 0);
    repeat (6) @(posedge i_clk);
    #2;
    i_DATA_LOADED = 1'b1; i_SAMPLES_NUMBER = AW'(8);
    @(negedge i_clk);
    chk("busy_during_ignored_start", o_BUSY, 1);
    @(posedge i_clk); #2;
    i_DATA_LOADED = 1'b0;
    finish_frame(32);

    // Write-back every cycle: single outstanding, one-cycle drains
    wb_lat = 1; rdy_mode = 0;
    start_frame(32, 1, 1);
    finish_frame(80);

    // Reset in stage 1
    wb_lat = 2;
    start_frame(8, 1, 1);
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(posedge i_clk);
      ok = (last_stage == 1);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL reach_stage1: got last_stage=%0d expected 1", last_stage);
    end
    #2;
    i_rst = 1'b1;
    expq.delete(); wbq.delete();
    @(negedge i_clk);
    @(negedge i_clk);
    chk_all_zero("reset_mid_issue");
    @(posedge i_clk); #1;
    i_rst = 1'b0; stray_wb = 1'b1;
    @(posedge i_clk); #1;
    stray_wb = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      chk_all_zero("idle_after_stray_wb");
    end
    wb_lat = 3;
    start_frame(8, 1, 0);
    finish_frame(12);

    // Randomized frames
    repeat (4) begin
      lg = $urandom_range(2, 8);
      n = 1 << lg;
      wb_lat = $urandom_range(1, 6);
      rdy_mode = $urandom_range(0, 1);
      start_frame(n, 1, 1);
      finish_frame((n / 2) * lg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
